// File: rtl/alu_result_stage.sv
// ALU result stage: captures a double-width ALU result and serialises it to the bus one word per beat.
// Optional feature: define ZSTAGE_FLAGS_EN to add the registered zero_flag/neg_flag outputs.
module alu_result_stage #(
  parameter int          REG_SIZE = 32,
  parameter logic [3:0]  OP_MUL   = 4'b1000
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [2*REG_SIZE-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_SIZE-1:0]   out_data,
  output logic                  out_hi,
  output logic                  out_last,
  output logic [REG_SIZE-1:0]   hi_q,
  output logic [REG_SIZE-1:0]   lo_q
`ifdef ZSTAGE_FLAGS_EN
  ,
  output logic                  zero_flag,
  output logic                  neg_flag
`endif
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    SINGLE  = 2'd1,
    LO_BEAT = 2'd2,
    HI_BEAT = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [REG_SIZE-1:0] hi_word;
  logic                accept;
  logic                pop;
  logic                is_mul;

  // Beat attributes decode straight from the state register, so no input reaches them combinationally.
  assign out_valid = (state != EMPTY);
  assign out_last  = (state == SINGLE) || (state == HI_BEAT);
  assign out_hi    = (state == HI_BEAT);

  // Accepting while the final beat drains keeps back-to-back results bubble-free.
  assign in_ready = (state == EMPTY) || (out_last && out_ready);
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign is_mul   = (in_op == OP_MUL);

  always_comb begin
    // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      EMPTY: begin
        if (accept) state_nxt = is_mul ? LO_BEAT : SINGLE;
      end
      LO_BEAT: begin
        if (pop) state_nxt = HI_BEAT;
      end
      SINGLE, HI_BEAT: begin
        if (accept)   state_nxt = is_mul ? LO_BEAT : SINGLE;
        else if (pop) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!clr) state <= EMPTY;
    else      state <= state_nxt;
  end

  // out_data holds the current beat; hi_word parks the upper half until the LO beat is consumed.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      out_data <= '0;
      hi_word  <= '0;
    end else if (accept) begin
      out_data <= in_data[REG_SIZE-1:0];
      hi_word  <= in_data[2*REG_SIZE-1:REG_SIZE];
    end else if (pop && (state == LO_BEAT)) begin
      out_data <= hi_word;
    end
  end

  // HI/LO update together at MUL acceptance, so a reset mid-transfer cannot leave them split.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (accept && is_mul) begin
      hi_q <= in_data[2*REG_SIZE-1:REG_SIZE];
      lo_q <= in_data[REG_SIZE-1:0];
    end
  end

`ifdef ZSTAGE_FLAGS_EN
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      zero_flag <= 1'b0;
      neg_flag  <= 1'b0;
    end else if (accept) begin
      if (is_mul) begin
        zero_flag <= (in_data == '0);
        neg_flag  <= in_data[2*REG_SIZE-1];
      end else begin
        zero_flag <= (in_data[REG_SIZE-1:0] == '0);
        neg_flag  <= in_data[REG_SIZE-1];
      end
    end
  end
`endif

endmodule
